cpu_memory: RTL and testbench

Moxie pipeline memory stage, consuming the execute-stage result bundle: memory address, store data, ALU result, write index and control bits. Performs data loads and stores over a Wishbone-classic data port. Forwards or replaces the register result for writeback and raises a load-to-PC branch for returns. While a bus cycle is outstanding, stall_o holds back the upstream stages.

---
 rtl/cpu_memory_pkg.sv | 22 ++
 rtl/cpu_memory_lane.sv | 45 ++++
 rtl/cpu_memory.sv | 237 +++++++++++++++++++++++
 tb/tb_cpu_memory.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_memory_pkg.sv
// Shared definitions for the Moxie memory stage: control-bit layout, access size codes and
// the bus state encoding.
package cpu_memory_pkg;

    localparam int unsigned PCB_WIDTH = 5;

    localparam int unsigned PCB_RW   = 0;
    localparam int unsigned PCB_MR   = 1;
    localparam int unsigned PCB_MW   = 2;
    localparam int unsigned PCB_M2R  = 3;
    localparam int unsigned PCB_M2PC = 4;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_S = 2'b01;
    localparam logic [1:0] SIZE_L = 2'b10;

    typedef enum logic {
        StIdle,
        StBus
    } state_e;

endpackage

// File: rtl/cpu_memory_lane.sv
// Big-endian byte lane logic: select generation, store replication and load extraction with
// zero-extension. Code 2'b11 falls through to the long case.
module cpu_memory_lane
    import cpu_memory_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  sel_o,
    output logic [31:0] store_word_o,
    output logic [31:0] load_data_o
);

    always_comb begin
        sel_o        = 4'b1111;
        store_word_o = store_data_i;
        load_data_o  = load_word_i;
        case (size_i)
            SIZE_B: begin
                sel_o        = 4'b1000 >> addr_lo_i;
                store_word_o = {4{store_data_i[7:0]}};
                // Lane 3 (bits 31:24) holds the byte at offset 0.
                case (addr_lo_i)
                    2'd0:    load_data_o = {24'h0, load_word_i[31:24]};
                    2'd1:    load_data_o = {24'h0, load_word_i[23:16]};
                    2'd2:    load_data_o = {24'h0, load_word_i[15:8]};
                    default: load_data_o = {24'h0, load_word_i[7:0]};
                endcase
            end
            SIZE_S: begin
                store_word_o = {2{store_data_i[15:0]}};
                if (addr_lo_i[1]) begin
                    sel_o       = 4'b0011;
                    load_data_o = {16'h0, load_word_i[15:0]};
                end else begin
                    sel_o       = 4'b1100;
                    load_data_o = {16'h0, load_word_i[31:16]};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_memory.sv
// Moxie memory stage with a Wishbone-classic data port. Define CPU_MEMORY_TIMEOUT_EN to add a
// bus watchdog that aborts a cycle after TIMEOUT_CYCLES without acknowledge.
module cpu_memory
    import cpu_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
    input  logic [1:0]           mem_size_i,
    input  logic [31:0]          memory_address_i,
    input  logic [31:0]          mem_result_i,
    input  logic [31:0]          reg_result_i,
    input  logic [3:0]           register_write_index_i,
    output logic [31:0]          reg_result_o,
    output logic [3:0]           register_write_index_o,
    output logic                 reg_write_o,
    output logic                 branch_flag_o,
    output logic [31:0]          branch_target_o,
    output logic                 stall_o,
    output logic [31:0]          dat_adr_o,
    output logic [31:0]          dat_dat_o,
    input  logic [31:0]          dat_dat_i,
    output logic [3:0]           dat_sel_o,
    output logic                 dat_we_o,
    output logic                 dat_cyc_o,
    output logic                 dat_stb_o,
    input  logic                 dat_ack_i,
    output logic                 bus_error_o
);

    state_e      state_q, state_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;
    logic        m2pc_q, m2pc_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] rres_q, rres_d;
    logic [3:0]  idx_q, idx_d;

    logic [31:0] reg_result_q, reg_result_d;
    logic [3:0]  wb_idx_q, wb_idx_d;
    logic        reg_write_q, reg_write_d;
    logic        branch_flag_q, branch_flag_d;
    logic [31:0] branch_target_q, branch_target_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;

    logic        mem_op;
    logic        timeout_hit;
    logic [1:0]  lane_size;
    logic [1:0]  lane_addr_lo;
    logic [3:0]  lane_sel;
    logic [31:0] lane_store;
    logic [31:0] lane_load;

`ifdef CPU_MEMORY_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_error_q, bus_error_d;

    assign timeout_hit = (state_q == StBus) && (32'(cnt_q) >= TIMEOUT_CYCLES - 1);
    assign bus_error_o = bus_error_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_error_o = 1'b0;
`endif

    assign mem_op = pipeline_control_bits_i[PCB_MR] | pipeline_control_bits_i[PCB_MW];

    // One lane instance serves both paths: store fields come from the inputs at acceptance,
    // load extraction uses the op latched for the cycle in flight.
    assign lane_size    = (state_q == StBus) ? size_q : mem_size_i;
    assign lane_addr_lo = (state_q == StBus) ? addr_lo_q : memory_address_i[1:0];

    cpu_memory_lane u_lane (
        .size_i       (lane_size),
        .addr_lo_i    (lane_addr_lo),
        .store_data_i (mem_result_i),
        .load_word_i  (dat_dat_i),
        .sel_o        (lane_sel),
        .store_word_o (lane_store),
        .load_data_o  (lane_load)
    );

    always_comb begin
        state_d         = state_q;
        rw_d            = rw_q;
        m2r_d           = m2r_q;
        m2pc_d          = m2pc_q;
        size_d          = size_q;
        addr_lo_d       = addr_lo_q;
        rres_d          = rres_q;
        idx_d           = idx_q;
        reg_result_d    = reg_result_q;
        wb_idx_d        = wb_idx_q;
        reg_write_d     = 1'b0;
        branch_flag_d   = 1'b0;
        branch_target_d = branch_target_q;
        adr_d           = adr_q;
        dat_d           = dat_q;
        sel_d           = sel_q;
        we_d            = we_q;
        cyc_d           = cyc_q;
`ifdef CPU_MEMORY_TIMEOUT_EN
        cnt_d           = cnt_q;
        bus_error_d     = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (!stall_i) begin
                    if (mem_op) begin
                        state_d   = StBus;
                        rw_d      = pipeline_control_bits_i[PCB_RW];
                        m2r_d     = pipeline_control_bits_i[PCB_M2R];
                        m2pc_d    = pipeline_control_bits_i[PCB_M2PC];
                        size_d    = mem_size_i;
                        addr_lo_d = memory_address_i[1:0];
                        rres_d    = reg_result_i;
                        idx_d     = register_write_index_i;
                        adr_d     = {memory_address_i[31:2], 2'b00};
                        dat_d     = lane_store;
                        sel_d     = lane_sel;
                        we_d      = pipeline_control_bits_i[PCB_MW];
                        cyc_d     = 1'b1;
`ifdef CPU_MEMORY_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end else begin
                        reg_result_d = reg_result_i;
                        wb_idx_d     = register_write_index_i;
                        reg_write_d  = pipeline_control_bits_i[PCB_RW];
                    end
                end
            end
            StBus: begin
                if (dat_ack_i) begin
                    state_d      = StIdle;
                    cyc_d        = 1'b0;
                    we_d         = 1'b0;
                    sel_d        = 4'b0000;
                    reg_result_d = m2r_q ? lane_load : rres_q;
                    wb_idx_d     = idx_q;
                    reg_write_d  = rw_q;
                    if (m2pc_q) begin
                        branch_target_d = lane_load;
                        branch_flag_d   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = StIdle;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'b0000;
`ifdef CPU_MEMORY_TIMEOUT_EN
                    bus_error_d = 1'b1;
`endif
                end else begin
`ifdef CPU_MEMORY_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            rw_q            <= 1'b0;
            m2r_q           <= 1'b0;
            m2pc_q          <= 1'b0;
            size_q          <= 2'b00;
            addr_lo_q       <= 2'b00;
            rres_q          <= '0;
            idx_q           <= '0;
            reg_result_q    <= '0;
            wb_idx_q        <= '0;
            reg_write_q     <= 1'b0;
            branch_flag_q   <= 1'b0;
            branch_target_q <= '0;
            adr_q           <= '0;
            dat_q           <= '0;
            sel_q           <= '0;
            we_q            <= 1'b0;
            cyc_q           <= 1'b0;
`ifdef CPU_MEMORY_TIMEOUT_EN
            cnt_q           <= '0;
            bus_error_q     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            rw_q            <= rw_d;
            m2r_q           <= m2r_d;
            m2pc_q          <= m2pc_d;
            size_q          <= size_d;
            addr_lo_q       <= addr_lo_d;
            rres_q          <= rres_d;
            idx_q           <= idx_d;
            reg_result_q    <= reg_result_d;
            wb_idx_q        <= wb_idx_d;
            reg_write_q     <= reg_write_d;
            branch_flag_q   <= branch_flag_d;
            branch_target_q <= branch_target_d;
            adr_q           <= adr_d;
            dat_q           <= dat_d;
            sel_q           <= sel_d;
            we_q            <= we_d;
            cyc_q           <= cyc_d;
`ifdef CPU_MEMORY_TIMEOUT_EN
            cnt_q           <= cnt_d;
            bus_error_q     <= bus_error_d;
`endif
        end
    end

    assign stall_o = ((state_q == StIdle) && mem_op && !stall_i) ||
                     ((state_q == StBus) && !dat_ack_i && !timeout_hit);

    assign reg_result_o           = reg_result_q;
    assign register_write_index_o = wb_idx_q;
    assign reg_write_o            = reg_write_q;
    assign branch_flag_o          = branch_flag_q;
    assign branch_target_o        = branch_target_q;
    assign dat_adr_o              = adr_q;
    assign dat_dat_o              = dat_q;
    assign dat_sel_o              = sel_q;
    assign dat_we_o               = we_q;
    assign dat_cyc_o              = cyc_q;
    assign dat_stb_o              = cyc_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Scoreboard bench for cpu_memory: a driver pushes expected bus cycles and writebacks, a
// Wishbone slave process and a writeback monitor pop and compare.
module tb_cpu_memory;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic [4:0]  pipeline_control_bits_i;
    logic [1:0]  mem_size_i;
    logic [31:0] memory_address_i;
    logic [31:0] mem_result_i;
    logic [31:0] reg_result_i;
    logic [3:0]  register_write_index_i;
    logic [31:0] reg_result_o;
    logic [3:0]  register_write_index_o;
    logic        reg_write_o;
    logic        branch_flag_o;
    logic [31:0] branch_target_o;
    logic        stall_o;
    logic [31:0] dat_adr_o;
    logic [31:0] dat_dat_o;
    logic [31:0] dat_dat_i;
    logic [3:0]  dat_sel_o;
    logic        dat_we_o;
    logic        dat_cyc_o;
    logic        dat_stb_o;
    logic        dat_ack_i;
    logic        bus_error_o;

    cpu_memory #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .stall_i                 (stall_i),
        .pipeline_control_bits_i (pipeline_control_bits_i),
        .mem_size_i              (mem_size_i),
        .memory_address_i        (memory_address_i),
        .mem_result_i            (mem_result_i),
        .reg_result_i            (reg_result_i),
        .register_write_index_i  (register_write_index_i),
        .reg_result_o            (reg_result_o),
        .register_write_index_o  (register_write_index_o),
        .reg_write_o             (reg_write_o),
        .branch_flag_o           (branch_flag_o),
        .branch_target_o         (branch_target_o),
        .stall_o                 (stall_o),
        .dat_adr_o               (dat_adr_o),
        .dat_dat_o               (dat_dat_o),
        .dat_dat_i               (dat_dat_i),
        .dat_sel_o               (dat_sel_o),
        .dat_we_o                (dat_we_o),
        .dat_cyc_o               (dat_cyc_o),
        .dat_stb_o               (dat_stb_o),
        .dat_ack_i               (dat_ack_i),
        .bus_error_o             (bus_error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
        logic [31:0] rdata;
        int          waits;
    } bus_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  idx;
    } wb_t;

    bus_t        busq[$];
    wb_t         wbq[$];
    logic [31:0] brq[$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access size in bytes and big-endian lane arithmetic.
    function automatic int nbytes(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [1:0] s, input logic [31:0] a);
        int off = int'(a % 4);
        if (nbytes(s) == 1) return 4'(1 << (3 - off));
        if (nbytes(s) == 2) return (off >= 2) ? 4'd3 : 4'd12;
        return 4'd15;
    endfunction

    function automatic logic [31:0] exp_store(input logic [1:0] s, input logic [31:0] d);
        if (nbytes(s) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (nbytes(s) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] s, input logic [31:0] a,
                                             input logic [31:0] w);
        int off = int'(a % 4);
        if (nbytes(s) == 1) return (w >> (8 * (3 - off))) & 32'hFF;
        if (nbytes(s) == 2) return (w >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
        return w;
    endfunction

    // Wishbone slave: checks each cycle against the expected queue, then acks after waits.
    initial begin
        bus_t e;
        dat_ack_i = 1'b0;
        dat_dat_i = 32'h0;
        forever begin
            @(negedge clk_i);
            if (dat_cyc_o === 1'b1 && rst_i === 1'b0) begin
                if (busq.size() == 0) begin
                    check("unexpected_bus_cycle", 32'd1, 32'd0);
                    e.adr = 0; e.sel = 0; e.we = 0; e.dat = 0; e.rdata = 0; e.waits = 0;
                end else begin
                    e = busq.pop_front();
                    check("bus_adr", dat_adr_o, e.adr);
                    check("bus_sel", {28'h0, dat_sel_o}, {28'h0, e.sel});
                    check("bus_we", {31'h0, dat_we_o}, {31'h0, e.we});
                    check("bus_stb", {31'h0, dat_stb_o}, 32'd1);
                    if (e.we) check("bus_wdata", dat_dat_o, e.dat);
                end
                for (int w = 0; w < e.waits && dat_cyc_o; w++) begin
                    if (e.waits < 50) check("stall_wait", {31'h0, stall_o}, 32'd1);
                    @(negedge clk_i);
                end
                if (dat_cyc_o) begin
                    dat_dat_i = e.rdata;
                    dat_ack_i = 1'b1;
                    #1 check("stall_ack", {31'h0, stall_o}, 32'd0);
                    @(negedge clk_i);
                    dat_ack_i = 1'b0;
                    dat_dat_i = $urandom;
                    check("cyc_drop", {31'h0, dat_cyc_o}, 32'd0);
                end
            end
        end
    end

    // Writeback and branch monitor.
    initial begin
        wb_t w;
        logic [31:0] t;
        forever begin
            @(negedge clk_i);
            if (rst_i === 1'b0) begin
                if (reg_write_o === 1'b1) begin
                    if (wbq.size() == 0) check("unexpected_writeback", 32'd1, 32'd0);
                    else begin
                        w = wbq.pop_front();
                        check("wb_result", reg_result_o, w.res);
                        check("wb_index", {28'h0, register_write_index_o}, {28'h0, w.idx});
                    end
                end
                if (branch_flag_o === 1'b1) begin
                    if (brq.size() == 0) check("unexpected_branch", 32'd1, 32'd0);
                    else begin
                        t = brq.pop_front();
                        check("branch_target", branch_target_o, t);
                    end
                end
            end
        end
    end

    task automatic do_op(input logic [4:0] pcb, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] mdata, input logic [31:0] rres, input logic [3:0] idx,
                         input logic stl, input int waits, input logic [31:0] rdata);
        bus_t e;
        wb_t w;
        logic memop;
        logic [31:0] ld;
        int n;
        @(negedge clk_i);
        pipeline_control_bits_i = pcb;
        mem_size_i              = size;
        memory_address_i        = addr;
        mem_result_i            = mdata;
        reg_result_i            = rres;
        register_write_index_i  = idx;
        stall_i                 = stl;
        memop = !stl && (pcb[1] || pcb[2]);
        ld = exp_load(size, addr, rdata);
        if (!stl) begin
            if (memop) begin
                e.adr = addr & 32'hFFFF_FFFC; e.sel = exp_sel(size, addr); e.we = pcb[2];
                e.dat = exp_store(size, mdata); e.rdata = rdata; e.waits = waits;
                busq.push_back(e);
                if (pcb[4]) brq.push_back(ld);
                if (pcb[0]) begin
                    w.res = (pcb[3] && !pcb[2]) ? ld : rres;
                    w.idx = idx;
                    wbq.push_back(w);
                end
            end else if (pcb[0]) begin
                w.res = rres;
                w.idx = idx;
                wbq.push_back(w);
            end
        end
        #1 check("stall_accept", {31'h0, stall_o}, {31'h0, memop});
        @(negedge clk_i);
        pipeline_control_bits_i = 5'b0;
        stall_i                 = 1'b0;
        memory_address_i        = $urandom;
        reg_result_i            = $urandom;
        mem_result_i            = $urandom;
        if (memop) begin
            n = 0;
            while (dat_cyc_o && n < 300) begin
                @(negedge clk_i);
                n++;
            end
            if (dat_cyc_o) check("bus_hang", 32'd1, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus_t e;
        logic [4:0] pcb;
        int n;
        rst_i = 1'b1;
        stall_i = 1'b0;
        pipeline_control_bits_i = 5'b0;
        mem_size_i = 2'b00;
        memory_address_i = 32'h0;
        mem_result_i = 32'h0;
        reg_result_i = 32'h0;
        register_write_index_i = 4'h0;
        #1;
        check("rst_reg_result", reg_result_o, 32'h0);
        check("rst_reg_write", {31'h0, reg_write_o}, 32'd0);
        check("rst_cyc", {31'h0, dat_cyc_o}, 32'd0);
        check("rst_branch", {31'h0, branch_flag_o}, 32'd0);
        check("rst_adr", dat_adr_o, 32'h0);
        check("rst_bus_error", {31'h0, bus_error_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        do_op(5'b00001, 2'b10, 32'h0,    32'h0,        32'h1234, 4'd5,  1'b0, 0, 32'h0);
        do_op(5'b01011, 2'b10, 32'h1003, 32'h0,        32'h0,    4'd2,  1'b0, 3, 32'hDEADBEEF);
        do_op(5'b00100, 2'b00, 32'h2002, 32'hAB,       32'h0,    4'd0,  1'b0, 1, 32'h0);
        do_op(5'b01011, 2'b01, 32'h3002, 32'h0,        32'h0,    4'd4,  1'b0, 0, 32'h1122BEEF);
        do_op(5'b10011, 2'b10, 32'h7FF0, 32'h0,        32'h7FF8, 4'd1,  1'b0, 1, 32'h400);
        do_op(5'b00011, 2'b10, 32'h100,  32'h0,        32'h55,   4'd7,  1'b1, 0, 32'h0);
        do_op(5'b00101, 2'b10, 32'h4000, 32'hCAFEF00D, 32'h3FFC, 4'd15, 1'b0, 2, 32'h0);
        do_op(5'b01011, 2'b11, 32'h4006, 32'h0,        32'h0,    4'd9,  1'b0, 0, 32'h0BADCAFE);

        // Reset in the middle of a bus cycle discards the op.
        @(negedge clk_i);
        pipeline_control_bits_i = 5'b01011;
        mem_size_i = 2'b10;
        memory_address_i = 32'h5000;
        register_write_index_i = 4'd3;
        e.adr = 32'h5000; e.sel = 4'hF; e.we = 1'b0; e.dat = 0; e.rdata = 32'h1; e.waits = 20;
        busq.push_back(e);
        @(negedge clk_i);
        pipeline_control_bits_i = 5'b0;
        @(negedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        check("midrst_cyc", {31'h0, dat_cyc_o}, 32'd0);
        check("midrst_stall", {31'h0, stall_o}, 32'd0);
        check("midrst_reg_write", {31'h0, reg_write_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);

`ifdef CPU_MEMORY_TIMEOUT_EN
        @(negedge clk_i);
        pipeline_control_bits_i = 5'b01011;
        mem_size_i = 2'b10;
        memory_address_i = 32'h6000;
        e.adr = 32'h6000; e.sel = 4'hF; e.we = 1'b0; e.dat = 0; e.rdata = 32'h2; e.waits = 100;
        busq.push_back(e);
        @(negedge clk_i);
        pipeline_control_bits_i = 5'b0;
        n = 1;
        while (bus_error_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_cyc", {31'h0, dat_cyc_o}, 32'd0);
        check("timeout_stall", {31'h0, stall_o}, 32'd0);
        @(negedge clk_i);
        check("timeout_pulse", {31'h0, bus_error_o}, 32'd0);
`endif

        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 2))
                0:       pcb = {4'b0000, 1'($urandom)};
                1:       pcb = {1'($urandom_range(0, 3) == 0), 1'($urandom), 2'b01, 1'($urandom)};
                default: pcb = {2'b00, 2'b10, 1'($urandom)};
            endcase
            do_op(pcb, 2'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
                  1'($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom);
        end

        repeat (5) @(negedge clk_i);
        check("wbq_drained", wbq.size(), 32'd0);
        check("brq_drained", brq.size(), 32'd0);
        check("busq_drained", busq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
